prbs7_checker_32b: RTL

- Receive-side PRBS7 checker for the SEU/SEE test bench; consumes the 32-bit-per-clock PRBS7 word stream after it passes through the DUT link.
- Self-synchronises to the incoming stream, then runs a free-running local PRBS7 model.
- Compares every valid word against the model and accumulates bit, word and lock-loss error counts for readout.

---
 rtl/prbs7_pkg.sv | 44 ++++
 rtl/prbs7_err_accum.sv | 78 +++++++
 rtl/prbs7_checker_32b.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/prbs7_pkg.sv
// Shared PRBS7 (x^7 + x^6 + 1) definitions for the 32-bit/clock generator and checker.
// Latency: none (types, constants and pure functions only).
// Backpressure: not applicable.
//
// Stream bits obey b[n+7] = b[n] ^ b[n+1]. A 7-bit state S holds the first seven
// bits of a word (S[i] = b[i] = word bit 31-i). The word's earliest bit sits in bit 31.
package prbs7_pkg;

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } chk_state_t;

    localparam logic [6:0] PRBS7_SEED = 7'h7F;

    // 32-bit word whose first seven stream bits are S.
    function automatic logic [31:0] prbs7_expand32(input logic [6:0] s);
        logic [31:0] b;
        logic [31:0] w;
        b      = '0;
        b[6:0] = s;
        for (int n = 7; n < 32; n++) begin
            b[n] = b[n-7] ^ b[n-6];
        end
        w = '0;
        for (int i = 0; i < 32; i++) begin
            w[31-i] = b[i];
        end
        return w;
    endfunction

    // State of the following word: stream bits 32..38 counted from S.
    function automatic logic [6:0] prbs7_advance32(input logic [6:0] s);
        logic [38:0] b;
        b      = '0;
        b[6:0] = s;
        for (int n = 7; n < 39; n++) begin
            b[n] = b[n-7] ^ b[n-6];
        end
        return b[38:32];
    endfunction

endpackage

// File: rtl/prbs7_err_accum.sv
// Popcount of the per-word mismatch plus saturating bit/word/lock-loss error counters.
// Latency: 1 cycle, all outputs registered on the edge that samples i_vld.
// Backpressure: none; i_vld=0 holds flag/popcount, counters only move on events or clear.
//
// Ports: CLK/RSTn clock and sync active-low reset; i_vld word checked this cycle;
// i_diff mismatch vector (zero outside LOCKED); i_lock_loss lock dropped this cycle;
// i_clr counter clear; o_err_flag/o_err_bits last word result; o_*_cnt totals.
module prbs7_err_accum #(
    parameter int CNT_W = 32
) (
    input  logic             CLK,
    input  logic             RSTn,
    input  logic             i_vld,
    input  logic [31:0]      i_diff,
    input  logic             i_lock_loss,
    input  logic             i_clr,
    output logic             o_err_flag,
    output logic [5:0]       o_err_bits,
    output logic [CNT_W-1:0] o_err_bit_cnt,
    output logic [CNT_W-1:0] o_err_word_cnt,
    output logic [CNT_W-1:0] o_lock_loss_cnt
);

    logic [5:0]       w_pop;
    logic [CNT_W-1:0] w_bit_inc;
    logic [CNT_W-1:0] w_word_inc;
    logic [CNT_W-1:0] w_ll_inc;
    logic [CNT_W-1:0] r_err_bit_cnt;
    logic [CNT_W-1:0] r_err_word_cnt;
    logic [CNT_W-1:0] r_lock_loss_cnt;
    logic             r_err_flag;
    logic [5:0]       r_err_bits;

    // Add with clamp at all-ones; counters never wrap.
    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                                 input logic [CNT_W-1:0] b);
        logic [CNT_W:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[CNT_W] ? {CNT_W{1'b1}} : s[CNT_W-1:0];
    endfunction

    always_comb begin
        w_pop = '0;
        for (int i = 0; i < 32; i++) begin
            w_pop = w_pop + {5'd0, i_diff[i]};
        end
    end

    assign w_bit_inc  = i_vld ? CNT_W'(w_pop) : '0;
    assign w_word_inc = (i_vld && (w_pop != 6'd0)) ? CNT_W'(1) : '0;
    assign w_ll_inc   = i_lock_loss ? CNT_W'(1) : '0;

    // Clear wins over the old value but not over this cycle's increment.
    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            r_err_bit_cnt   <= '0;
            r_err_word_cnt  <= '0;
            r_lock_loss_cnt <= '0;
            r_err_flag      <= 1'b0;
            r_err_bits      <= '0;
        end else begin
            r_err_bit_cnt   <= sat_add(i_clr ? '0 : r_err_bit_cnt,   w_bit_inc);
            r_err_word_cnt  <= sat_add(i_clr ? '0 : r_err_word_cnt,  w_word_inc);
            r_lock_loss_cnt <= sat_add(i_clr ? '0 : r_lock_loss_cnt, w_ll_inc);
            if (i_vld) begin
                r_err_flag <= (w_pop != 6'd0);
                r_err_bits <= w_pop;
            end
        end
    end

    assign o_err_flag      = r_err_flag;
    assign o_err_bits      = r_err_bits;
    assign o_err_bit_cnt   = r_err_bit_cnt;
    assign o_err_word_cnt  = r_err_word_cnt;
    assign o_lock_loss_cnt = r_lock_loss_cnt;

endmodule

// File: rtl/prbs7_checker_32b.sv
// Receive-side PRBS7 checker: self-syncs to a 32-bit/clock stream, then counts errors.
// Latency: 1 cycle, lock and error outputs registered on the edge sampling the word.
// Backpressure: none; data_valid=0 freezes FSM, model and counters.
//
// Ports: CLK, RSTn (sync active-low); data_in (bit 31 earliest) with data_valid;
// clr_cnt clears counters only; locked; err_flag/err_bits for the last checked word;
// err_bit_cnt, err_word_cnt, lock_loss_cnt saturating totals of width CNT_W.
module prbs7_checker_32b
    import prbs7_pkg::*;
#(
    parameter int CNT_W      = 32,
    parameter int LOCK_CNT   = 8,
    parameter int UNLOCK_CNT = 4
) (
    input  logic             CLK,
    input  logic             RSTn,
    input  logic [31:0]      data_in,
    input  logic             data_valid,
    input  logic             clr_cnt,
    output logic             locked,
    output logic             err_flag,
    output logic [5:0]       err_bits,
    output logic [CNT_W-1:0] err_bit_cnt,
    output logic [CNT_W-1:0] err_word_cnt,
    output logic [CNT_W-1:0] lock_loss_cnt
);

    localparam int MW = $clog2(LOCK_CNT + 1);
    localparam int BW = $clog2(UNLOCK_CNT + 1);

    chk_state_t  r_state;
    chk_state_t  w_state_nxt;
    logic [6:0]  r_exp_state;
    logic [6:0]  w_exp_nxt;
    logic [MW-1:0] r_match_cnt;
    logic [MW-1:0] w_match_nxt;
    logic [BW-1:0] r_bad_cnt;
    logic [BW-1:0] w_bad_nxt;

    logic [6:0]  w_s_rx;
    logic [6:0]  w_adv_rx;
    logic [6:0]  w_adv_exp;
    logic [31:0] w_exp_word;
    logic [31:0] w_diff;
    logic        w_lock_loss;

    // First seven bits of the received word as a generator state (bit 31 -> S[0]).
    always_comb begin
        w_s_rx = '0;
        for (int i = 0; i < 7; i++) begin
            w_s_rx[i] = data_in[31-i];
        end
    end

    assign w_adv_rx   = prbs7_advance32(w_s_rx);
    assign w_adv_exp  = prbs7_advance32(r_exp_state);
    assign w_exp_word = prbs7_expand32(r_exp_state);

    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            r_state     <= SEARCH;
            r_exp_state <= '0;
            r_match_cnt <= '0;
            r_bad_cnt   <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_exp_state <= w_exp_nxt;
            r_match_cnt <= w_match_nxt;
            r_bad_cnt   <= w_bad_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_exp_nxt   = r_exp_state;
        w_match_nxt = r_match_cnt;
        w_bad_nxt   = r_bad_cnt;
        w_diff      = '0;
        w_lock_loss = 1'b0;
        if (data_valid) begin
            case (r_state)
                SEARCH: begin
                    // An all-zero seed would lock onto a dead link; refuse it.
                    if (w_s_rx != 7'd0) begin
                        w_exp_nxt   = w_adv_rx;
                        w_match_nxt = '0;
                        w_state_nxt = VERIFY;
                    end
                end
                VERIFY: begin
                    if (data_in == w_exp_word) begin
                        w_exp_nxt = w_adv_exp;
                        if (r_match_cnt == MW'(LOCK_CNT - 1)) begin
                            w_match_nxt = '0;
                            w_bad_nxt   = '0;
                            w_state_nxt = LOCKED;
                        end else begin
                            w_match_nxt = r_match_cnt + MW'(1);
                        end
                    end else begin
                        w_match_nxt = '0;
                        if (w_s_rx == 7'd0) begin
                            w_state_nxt = SEARCH;
                        end else begin
                            w_exp_nxt = w_adv_rx;
                        end
                    end
                end
                LOCKED: begin
                    // Model free-runs regardless of errors so one bad word costs one word.
                    w_diff    = data_in ^ w_exp_word;
                    w_exp_nxt = w_adv_exp;
                    if (w_diff != 32'd0) begin
                        if (r_bad_cnt == BW'(UNLOCK_CNT - 1)) begin
                            w_bad_nxt   = '0;
                            w_lock_loss = 1'b1;
                            w_state_nxt = SEARCH;
                        end else begin
                            w_bad_nxt = r_bad_cnt + BW'(1);
                        end
                    end else begin
                        w_bad_nxt = '0;
                    end
                end
                default: begin
                    w_state_nxt = SEARCH;
                end
            endcase
        end
    end

    assign locked = (r_state == LOCKED);

    prbs7_err_accum #(
        .CNT_W (CNT_W)
    ) u_accum (
        .CLK             (CLK),
        .RSTn            (RSTn),
        .i_vld           (data_valid),
        .i_diff          (w_diff),
        .i_lock_loss     (w_lock_loss),
        .i_clr           (clr_cnt),
        .o_err_flag      (err_flag),
        .o_err_bits      (err_bits),
        .o_err_bit_cnt   (err_bit_cnt),
        .o_err_word_cnt  (err_word_cnt),
        .o_lock_loss_cnt (lock_loss_cnt)
    );

endmodule
